reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  ID-stage register scoreboard: tracks in-flight writes per architectural register with saturating counters.
//  Holds issue (stall) on RAW hazards against pending writes; supports N read ports, M write-back ports, and a pipeline flush.
//  Sits after the register-address decoder; consumes its read/write enables and addresses; wb ports driven by WB stage(s).
// PARAMETERS
//  REG_ADDR_WIDTH  5  register address width; tracks 2**REG_ADDR_WIDTH regs, reg 0 never tracked
//  NUM_READ_PORTS  2  operand read ports checked per issue
//  NUM_WB_PORTS    2  write-back (release) ports per cycle
//  CNT_WIDTH       2  per-reg pending counter width; CNT_MAX = 2**CNT_WIDTH-1 in-flight writes per reg
// PORTS
//  clk             in   1                              clock
//  rst             in   1                              synchronous, active-high reset
//  flush           in   1                              clear all pending counts (pipeline flush)
//  issue_valid     in   1                              decoded instruction present in ID
//  issue_ready     out  1                              no hazard; issue fires when issue_valid & issue_ready
//  read_en         in   NUM_READ_PORTS                 per-port operand read enable
//  read_addr       in   NUM_READ_PORTS*REG_ADDR_WIDTH  port k at [k*W +: W]
//  write_en        in   1                              issuing instr writes a register
//  write_addr      in   REG_ADDR_WIDTH                 destination register
//  wb_valid        in   NUM_WB_PORTS                   write-back completed on port j
//  wb_addr         in   NUM_WB_PORTS*REG_ADDR_WIDTH    port j at [j*W +: W]
//  stall           out  1                              issue_valid & hazard
//  busy_mask       out  2**REG_ADDR_WIDTH              bit i = (cnt[i] != 0); bit 0 always 0
//  underflow_err   out  1                              sticky: release seen with no pending write
// BEHAVIOUR
//  - State: cnt[i], CNT_WIDTH bits, i = 1..2**REG_ADDR_WIDTH-1; underflow_err flop.
//  - Reset (rst=1 at posedge): all cnt=0, underflow_err=0. While rst=1: issue_ready=0, stall=0; busy_mask reflects cnt.
//  - hazard (combinational, from registered cnt only; no same-cycle wb bypass):
//     RAW: any k with read_en[k] & read_addr_k!=0 & cnt[read_addr_k]!=0.
//     SAT: write_en & write_addr!=0 & cnt[write_addr]==CNT_MAX.
//     WAW is allowed (counter increments); reads/writes of reg 0 never hazard.
//  - issue_ready = ~rst & ~hazard; stall = ~rst & issue_valid & hazard. Independent of issue_valid for ready.
//  - fire = issue_valid & issue_ready.
//  - Per reg i (i!=0), each cycle:
//     inc = fire & write_en & (write_addr==i)                      (0 or 1)
//     dec = count of j with wb_valid[j] & (wb_addr_j==i)           (0..NUM_WB_PORTS)
//     next = cnt + inc - dec, computed at CNT_WIDTH+clog2(NUM_WB_PORTS)+1 bits.
//     if dec > cnt+inc: next = 0, set underflow_err.
//     Overflow cannot occur (SAT hazard blocks issue at CNT_MAX).
//  - Simultaneous issue and wb to the same reg in one cycle: both applied (net cnt+1-dec).
//  - wb to reg 0 ignored (no dec, no error).
//  - flush=1: next cycle all cnt=0; overrides issue and wb that cycle; no underflow check that cycle.
//    underflow_err is cleared only by rst.
//  - Latency: cnt, busy_mask, and hazard reflect an issue/wb on the cycle after the clock edge.
//  - rst mid-operation: all pending state discarded; identical to power-on.
// TESTING
//  1. rst 2 cycles -> busy_mask=0, underflow_err=0, issue_ready=0 during rst, 1 after.
//  2. Issue write_addr=5; next cycle read_addr0=5, read_en=01, issue_valid=1 -> stall=1, issue_ready=0;
//     wb_valid=01, wb_addr0=5 -> stall=0 the following cycle, busy_mask[5]=0.
//  3. Issue write_addr=7 three times (CNT_WIDTH=2) -> cnt[7]=3; 4th issue with write_addr=7 -> stall=1 (SAT);
//     one wb to 7 -> issue_ready=1.
//  4. cnt[9]=1; same cycle: issue write 9 plus wb_valid=11, wb_addr0=9, wb_addr1=9 -> cnt[9]=0, no error;
//     then a single wb to 9 with cnt=0 -> underflow_err=1 and stays 1.
//  5. busy regs 3,4; flush=1 together with issue write 6 and wb 3 -> next cycle busy_mask=0, underflow_err unchanged.
//  6. Reads/writes/wb of reg 0 with any pending state -> never stall, busy_mask[0]=0, no error.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Scoreboard bundle: issue/read/write enables from the ID decoder, write-back releases,
// and the hazard/busy status returned to the issue logic.
interface reg_scoreboard_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned NUM_WB_PORTS   = 2
);
    logic                                     flush;
    logic                                     issue_valid;
    logic                                     issue_ready;
    logic [NUM_READ_PORTS-1:0]                read_en;
    logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr;
    logic                                     write_en;
    logic [REG_ADDR_WIDTH-1:0]                write_addr;
    logic [NUM_WB_PORTS-1:0]                  wb_valid;
    logic [NUM_WB_PORTS*REG_ADDR_WIDTH-1:0]   wb_addr;
    logic                                     stall;
    logic [(1<<REG_ADDR_WIDTH)-1:0]           busy_mask;
    logic                                     underflow_err;

    modport master (
        output flush, issue_valid, read_en, read_addr, write_en, write_addr, wb_valid, wb_addr,
        input  issue_ready, stall, busy_mask, underflow_err
    );

    modport slave (
        input  flush, issue_valid, read_en, read_addr, write_en, write_addr, wb_valid, wb_addr,
        output issue_ready, stall, busy_mask, underflow_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: saturating per-register pending-write counters that hold
// issue on RAW hazards or counter saturation, released by write-back ports.
module reg_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned NUM_WB_PORTS   = 2,
    parameter int unsigned CNT_WIDTH      = 2
) (
    input logic           clk,
    input logic           rst,
    reg_scoreboard_if.slave sb_if
);
    localparam int unsigned NumRegs = 1 << REG_ADDR_WIDTH;
    // Wide enough for cnt + 1 and up to NUM_WB_PORTS releases without wrap.
    localparam int unsigned ExtW    = CNT_WIDTH + $clog2(NUM_WB_PORTS + 1) + 1;

    logic [CNT_WIDTH-1:0] cnt_q [NumRegs];
    logic [CNT_WIDTH-1:0] cnt_d [NumRegs];
    logic                 uf_q, uf_d;

    logic                      hazard_raw, hazard_sat, hazard, fire, uf_set;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [ExtW-1:0]           inc, dec, sum;
    logic [NumRegs-1:0]        busy;

    always_comb begin
        hazard_raw = 1'b0;
        rd_addr    = '0;
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
            rd_addr = sb_if.read_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            if (sb_if.read_en[k] && (rd_addr != '0) && (cnt_q[rd_addr] != '0)) begin
                hazard_raw = 1'b1;
            end
        end
        hazard_sat = sb_if.write_en && (sb_if.write_addr != '0) &&
                     (cnt_q[sb_if.write_addr] == {CNT_WIDTH{1'b1}});
        hazard     = hazard_raw | hazard_sat;
    end

    assign sb_if.issue_ready = ~rst & ~hazard;
    assign sb_if.stall       = ~rst & sb_if.issue_valid & hazard;
    assign fire              = sb_if.issue_valid & sb_if.issue_ready;

    always_comb begin
        cnt_d  = cnt_q;
        uf_set = 1'b0;
        inc    = '0;
        dec    = '0;
        sum    = '0;
        for (int unsigned i = 1; i < NumRegs; i++) begin
            inc = (fire && sb_if.write_en && (sb_if.write_addr == REG_ADDR_WIDTH'(i))) ?
                  ExtW'(1) : '0;
            dec = '0;
            for (int unsigned j = 0; j < NUM_WB_PORTS; j++) begin
                if (sb_if.wb_valid[j] &&
                    (sb_if.wb_addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(i))) begin
                    dec = dec + ExtW'(1);
                end
            end
            sum = ExtW'(cnt_q[i]) + inc;
            if (dec > sum) begin
                cnt_d[i] = '0;
                uf_set   = 1'b1;
            end else begin
                cnt_d[i] = CNT_WIDTH'(sum - dec);
            end
        end
        cnt_d[0] = '0;
        // Flush discards everything in flight, including this cycle's issue and releases.
        if (sb_if.flush) begin
            cnt_d  = '{default: '0};
            uf_set = 1'b0;
        end
        uf_d = uf_q | uf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
            uf_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 1; i < NumRegs; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign sb_if.busy_mask     = busy;
    assign sb_if.underflow_err = uf_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a small counter model pushes expected busy/error state
// into a queue each cycle; it is popped and compared after the clock edge.
module tb_reg_scoreboard;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 1 << AW;

    typedef struct packed {
        logic [NR-1:0] busy;
        logic          uf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt_m [NR];
    logic uf_m = 1'b0;
    exp_t exp_q [$];

    reg_scoreboard_if #(.REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(2), .NUM_WB_PORTS(2)) sb_if ();

    reg_scoreboard #(
        .REG_ADDR_WIDTH(AW),
        .NUM_READ_PORTS(2),
        .NUM_WB_PORTS  (2),
        .CNT_WIDTH     (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sb_if(sb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic iv, input logic [1:0] ren, input int ra0, input int ra1,
                          input logic we, input int wa, input logic [1:0] wbv,
                          input int wb0, input int wb1, input logic fl);
        sb_if.issue_valid = iv;
        sb_if.read_en     = ren;
        sb_if.read_addr   = {AW'(ra1), AW'(ra0)};
        sb_if.write_en    = we;
        sb_if.write_addr  = AW'(wa);
        sb_if.wb_valid    = wbv;
        sb_if.wb_addr     = {AW'(wb1), AW'(wb0)};
        sb_if.flush       = fl;
        #1;
    endtask

    function automatic logic model_hazard();
        int a0, a1, wa;
        a0 = int'(sb_if.read_addr[AW-1:0]);
        a1 = int'(sb_if.read_addr[2*AW-1:AW]);
        wa = int'(sb_if.write_addr);
        if (sb_if.read_en[0] && a0 != 0 && cnt_m[a0] > 0) return 1'b1;
        if (sb_if.read_en[1] && a1 != 0 && cnt_m[a1] > 0) return 1'b1;
        if (sb_if.write_en && wa != 0 && cnt_m[wa] == 3) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock: predict next state, then compare after the edge.
    task automatic tick(input string tag);
        exp_t e;
        logic fire;
        int   n;
        fire = !rst && sb_if.issue_valid && !model_hazard();
        if (rst || sb_if.flush) begin
            for (int i = 0; i < NR; i++) cnt_m[i] = 0;
            if (rst) uf_m = 1'b0;
        end else begin
            for (int i = 1; i < NR; i++) begin
                n = cnt_m[i];
                if (fire && sb_if.write_en && int'(sb_if.write_addr) == i) n++;
                if (sb_if.wb_valid[0] && int'(sb_if.wb_addr[AW-1:0]) == i) n--;
                if (sb_if.wb_valid[1] && int'(sb_if.wb_addr[2*AW-1:AW]) == i) n--;
                if (n < 0) begin
                    n    = 0;
                    uf_m = 1'b1;
                end
                cnt_m[i] = n;
            end
        end
        e.uf = uf_m;
        for (int i = 0; i < NR; i++) e.busy[i] = (cnt_m[i] != 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_busy"}, 64'(sb_if.busy_mask), 64'(e.busy));
        check({tag, "_uf"}, 64'(sb_if.underflow_err), 64'(e.uf));
    endtask

    initial begin
        for (int i = 0; i < NR; i++) cnt_m[i] = 0;
        // Reset behaviour: ready low, no stall even with a valid instruction present.
        set_in(1, 2'b00, 0, 0, 1, 5, 2'b00, 0, 0, 0);
        check("rst_ready", 64'(sb_if.issue_ready), 64'd0);
        check("rst_stall", 64'(sb_if.stall), 64'd0);
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        set_in(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        check("post_rst_ready", 64'(sb_if.issue_ready), 64'd1);

        // RAW hazard on reg 5, cleared by write-back.
        set_in(1, 2'b00, 0, 0, 1, 5, 2'b00, 0, 0, 0);
        tick("iss5");
        set_in(1, 2'b01, 5, 0, 0, 0, 2'b01, 5, 0, 0);
        check("raw5_stall", 64'(sb_if.stall), 64'd1);
        check("raw5_ready", 64'(sb_if.issue_ready), 64'd0);
        tick("wb5");
        set_in(1, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0);
        check("raw5_clear", 64'(sb_if.stall), 64'd0);
        check("busy5_clear", 64'(sb_if.busy_mask[5]), 64'd0);
        tick("rd5");

        // Saturation on reg 7.
        set_in(1, 2'b00, 0, 0, 1, 7, 2'b00, 0, 0, 0);
        tick("iss7a");
        tick("iss7b");
        tick("iss7c");
        check("sat7_stall", 64'(sb_if.stall), 64'd1);
        check("sat7_ready", 64'(sb_if.issue_ready), 64'd0);
        tick("sat7_hold");
        set_in(1, 2'b00, 0, 0, 1, 7, 2'b01, 7, 0, 0);
        check("sat7_nobypass", 64'(sb_if.stall), 64'd1);
        tick("wb7");
        check("sat7_release", 64'(sb_if.issue_ready), 64'd1);
        tick("iss7d");

        // Simultaneous issue and double release on reg 9, then underflow.
        set_in(1, 2'b00, 0, 0, 1, 9, 2'b00, 0, 0, 0);
        tick("iss9");
        set_in(1, 2'b00, 0, 0, 1, 9, 2'b11, 9, 9, 0);
        check("iss9_ready", 64'(sb_if.issue_ready), 64'd1);
        tick("iss9_wb2");
        check("cnt9_zero", 64'(sb_if.busy_mask[9]), 64'd0);
        set_in(0, 2'b00, 0, 0, 0, 0, 2'b01, 9, 0, 0);
        tick("uf9");
        check("uf_set", 64'(sb_if.underflow_err), 64'd1);
        set_in(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick("uf_sticky");

        // Flush overrides issue and write-back in the same cycle.
        set_in(1, 2'b00, 0, 0, 1, 3, 2'b00, 0, 0, 0);
        tick("iss3");
        set_in(1, 2'b00, 0, 0, 1, 4, 2'b00, 0, 0, 0);
        tick("iss4");
        set_in(1, 2'b00, 0, 0, 1, 6, 2'b01, 3, 0, 1);
        tick("flush");
        check("flush_busy", 64'(sb_if.busy_mask), 64'd0);
        check("flush_uf_kept", 64'(sb_if.underflow_err), 64'd1);

        // Reset mid-operation discards pending state and the error flag.
        set_in(1, 2'b00, 0, 0, 1, 2, 2'b00, 0, 0, 0);
        tick("iss2");
        rst = 1'b1;
        set_in(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick("rst_mid");
        rst = 1'b0;

        // Register 0 never hazards, never tracked, never underflows.
        set_in(1, 2'b00, 0, 0, 1, 11, 2'b00, 0, 0, 0);
        tick("iss11");
        set_in(1, 2'b11, 0, 0, 1, 0, 2'b11, 0, 0, 0);
        check("r0_stall", 64'(sb_if.stall), 64'd0);
        check("r0_ready", 64'(sb_if.issue_ready), 64'd1);
        tick("r0_ops");
        check("r0_busy", 64'(sb_if.busy_mask[0]), 64'd0);
        check("r0_no_uf", 64'(sb_if.underflow_err), 64'd0);
        set_in(1, 2'b10, 0, 11, 0, 0, 2'b00, 0, 0, 0);
        check("raw11_port1", 64'(sb_if.stall), 64'd1);
        tick("raw11_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
